// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: FSM encodings, opcode
// field layout, decoder opcodes and the default fetch timeout.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam int OPCODE_W = 5;

  // Decoder opcodes, found in the top OPCODE_W bits of the instruction word
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b0_0000;
  localparam logic [OPCODE_W-1:0] OP_VAL  = 5'b0_0001;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b1_1111;

  localparam int FETCH_TIMEOUT_DEFAULT = 15;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_fetch_watchdog.sv
// Fetch watchdog: down-counter reloaded to LIMIT while clr is high and
// decremented on each enabled cycle. expired flags the LIMIT-th enabled
// cycle so the FSM can leave FETCH on that same edge.
module fetch_watchdog
  import instr_sequencer_pkg::*;
#(
  parameter int LIMIT = FETCH_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CountW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CountW-1:0] count;

  // Reload on clr, otherwise count down once per waiting cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= CountW'(LIMIT);
    end else if (en && count != '0) begin
      count <= count - CountW'(1);
    end
  end

  // Terminal count: this enabled cycle is the last one allowed
  assign expired = en && (count == CountW'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches one instruction word into ir, gives the
// external decoder a single EXEC cycle and gates its write enables, and
// stops on HALT or on a fetch timeout.
//
//   state | meaning
//   IDLE  | waiting for run or a step pulse
//   FETCH | imem_req high, waiting for imem_ack (watchdog running)
//   EXEC  | one cycle, decoder enables passed through unless HALT
//   FAULT | fetch timed out; terminal until reset
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PROGRAM_DataWidth = 16,
  parameter int FetchTimeout      = FETCH_TIMEOUT_DEFAULT,
  parameter int RetireWidth       = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         step,
  output logic                         imem_req,
  input  logic                         imem_ack,
  input  logic [PROGRAM_DataWidth-1:0] imem_data,
  output logic [PROGRAM_DataWidth-1:0] ir,
  input  logic                         dec_wr_en,
  input  logic                         dec_stat_wr_en,
  input  logic                         dec_cnt_wr_en,
  output logic                         rf_wr_en,
  output logic                         stat_wr_en,
  output logic                         pc_load,
  output logic                         pc_inc,
  output logic                         halted,
  output logic                         fault,
  output logic [1:0]                   state,
  output logic [RetireWidth-1:0]       retired
);

  state_t                         state_q;
  logic [PROGRAM_DataWidth-1:0]   ir_q;
  logic                           imem_req_q;
  logic                           halted_q;
  logic                           fault_q;
  logic [RetireWidth-1:0]         retired_q;
  logic                           ir_is_halt;
  logic                           exec_live;
  logic                           wd_clr;
  logic                           wd_en;
  logic                           wd_expired;

  // Watchdog stays loaded outside FETCH so every fetch starts from a full count
  assign wd_clr = (state_q != ST_FETCH);
  assign wd_en  = (state_q == ST_FETCH) && !imem_ack;

  fetch_watchdog #(
    .LIMIT (FetchTimeout)
  ) u_fetch_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  assign ir_is_halt = is_halt(ir_q[PROGRAM_DataWidth-1 -: OPCODE_W]);

  // Sequencing FSM with registered imem_req/halted/fault/ir/retired
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!run) halted_q <= 1'b0;
          if ((run && !halted_q) || (step && !run)) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          // A late ack on the final allowed cycle still wins over the timeout
          if (imem_ack) begin
            ir_q       <= imem_data;
            state_q    <= ST_EXEC;
            imem_req_q <= 1'b0;
          end else if (wd_expired) begin
            state_q    <= ST_FAULT;
            fault_q    <= 1'b1;
            imem_req_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          retired_q <= retired_q + RetireWidth'(1);
          if (ir_is_halt) begin
            halted_q <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (run) begin
            state_q    <= ST_FETCH;
            imem_req_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_FAULT;
          fault_q    <= 1'b1;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Decoder enables only reach the datapath during a non-HALT EXEC cycle
  assign exec_live  = (state_q == ST_EXEC) && !ir_is_halt;
  assign rf_wr_en   = exec_live && dec_wr_en;
  assign stat_wr_en = exec_live && dec_stat_wr_en;
  assign pc_load    = exec_live && dec_cnt_wr_en;
  assign pc_inc     = exec_live && !dec_cnt_wr_en;

  assign imem_req = imem_req_q;
  assign ir       = ir_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. A second instance with a 4-bit
// retired counter shares the stimulus so the counter wrap is reachable.
module tb_instr_sequencer;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        step;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dec_wr_en;
  logic        dec_stat_wr_en;
  logic        dec_cnt_wr_en;

  logic        imem_req;
  logic [15:0] ir;
  logic        rf_wr_en, stat_wr_en, pc_load, pc_inc;
  logic        halted, fault;
  logic [1:0]  state;
  logic [15:0] retired;

  logic        w4_imem_req;
  logic [15:0] w4_ir;
  logic        w4_rf_wr_en, w4_stat_wr_en, w4_pc_load, w4_pc_inc;
  logic        w4_halted, w4_fault;
  logic [1:0]  w4_state;
  logic [3:0]  w4_retired;

  int n_cmp = 0;
  int n_bad = 0;

  instr_sequencer u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .step           (step),
    .imem_req       (imem_req),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .ir             (ir),
    .dec_wr_en      (dec_wr_en),
    .dec_stat_wr_en (dec_stat_wr_en),
    .dec_cnt_wr_en  (dec_cnt_wr_en),
    .rf_wr_en       (rf_wr_en),
    .stat_wr_en     (stat_wr_en),
    .pc_load        (pc_load),
    .pc_inc         (pc_inc),
    .halted         (halted),
    .fault          (fault),
    .state          (state),
    .retired        (retired)
  );

  instr_sequencer #(.RetireWidth(4)) u_dut_w4 (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .step           (step),
    .imem_req       (w4_imem_req),
    .imem_ack       (imem_ack),
    .imem_data      (imem_data),
    .ir             (w4_ir),
    .dec_wr_en      (dec_wr_en),
    .dec_stat_wr_en (dec_stat_wr_en),
    .dec_cnt_wr_en  (dec_cnt_wr_en),
    .rf_wr_en       (w4_rf_wr_en),
    .stat_wr_en     (w4_stat_wr_en),
    .pc_load        (w4_pc_load),
    .pc_inc         (w4_pc_inc),
    .halted         (w4_halted),
    .fault          (w4_fault),
    .state          (w4_state),
    .retired        (w4_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run = 1'b0; step = 1'b0; imem_ack = 1'b0;
    dec_wr_en = 1'b0; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] enables();
    return 32'({rf_wr_en, stat_wr_en, pc_load, pc_inc});
  endfunction

  initial begin
    imem_data = 16'h0000;
    do_reset();
    check_eq("rst_state",   32'(state), 32'd0);
    check_eq("rst_ir",      32'(ir), 32'h0);
    check_eq("rst_halted",  32'(halted), 32'd0);
    check_eq("rst_fault",   32'(fault), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_req",     32'(imem_req), 32'd0);
    check_eq("rst_en",      enables(), 32'h0);

    // Free-running VAL instructions: FETCH/EXEC alternate, pc_inc each EXEC
    run = 1'b1; imem_ack = 1'b1; imem_data = 16'h0900; dec_wr_en = 1'b1;
    tick();
    check_eq("run_first_fetch", 32'(state), 32'd1);
    check_eq("run_req",         32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("run_exec_state", 32'(state), 32'd2);
      check_eq("run_exec_ir",    32'(ir), 32'h0900);
      check_eq("run_exec_en",    enables(), 32'b1001);
      check_eq("run_exec_ret",   32'(retired), 32'(i));
      tick();
      check_eq("run_fetch_state", 32'(state), 32'd1);
      check_eq("run_fetch_ret",   32'(retired), 32'(i + 1));
      check_eq("run_fetch_en",    enables(), 32'h0);
    end

    // run dropped mid-FETCH: fetch completes, executes, then IDLE
    run = 1'b0; imem_ack = 1'b0;
    tick();
    check_eq("rundrop_fetch", 32'(state), 32'd1);
    imem_ack = 1'b1;
    tick();
    check_eq("rundrop_exec", 32'(state), 32'd2);
    imem_ack = 1'b0;
    tick();
    check_eq("rundrop_idle", 32'(state), 32'd0);
    check_eq("rundrop_ret",  32'(retired), 32'd4);
    tick();
    check_eq("rundrop_stay", 32'(state), 32'd0);
    check_eq("rundrop_req",  32'(imem_req), 32'd0);

    // ack outside FETCH is ignored
    imem_ack = 1'b1; imem_data = 16'h1234;
    tick();
    check_eq("ack_idle_ir", 32'(ir), 32'h0900);
    check_eq("ack_idle_state", 32'(state), 32'd0);
    imem_ack = 1'b0;

    // Single step with ack arriving on the third FETCH cycle
    do_reset();
    check_eq("rst2_ir", 32'(ir), 32'h0);
    imem_data = 16'h0A55; dec_wr_en = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_fetch", 32'(state), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("step_ign_fetch", 32'(state), 32'd1);
    tick();
    imem_ack = 1'b1;
    tick();
    check_eq("step_exec", 32'(state), 32'd2);
    check_eq("step_ir",   32'(ir), 32'h0A55);
    imem_ack = 1'b0;
    tick();
    check_eq("step_idle", 32'(state), 32'd0);
    check_eq("step_ret",  32'(retired), 32'd1);
    tick();
    tick();
    check_eq("step_stay",     32'(state), 32'd0);
    check_eq("step_stay_ret", 32'(retired), 32'd1);

    // PC load path
    dec_cnt_wr_en = 1'b1; dec_stat_wr_en = 1'b1; dec_wr_en = 1'b0;
    step = 1'b1; imem_ack = 1'b1;
    tick();
    step = 1'b0;
    check_eq("pcl_fetch_en", enables(), 32'h0);
    tick();
    check_eq("pcl_exec_en", enables(), 32'b0110);
    tick();
    check_eq("pcl_idle_en", enables(), 32'h0);
    imem_ack = 1'b0; dec_cnt_wr_en = 1'b0; dec_stat_wr_en = 1'b0;

    // HALT: zero enables, halted set, no refetch with run held
    run = 1'b1; imem_data = 16'hF800; imem_ack = 1'b1;
    dec_wr_en = 1'b1; dec_stat_wr_en = 1'b1; dec_cnt_wr_en = 1'b1;
    tick();
    tick();
    check_eq("halt_exec_state", 32'(state), 32'd2);
    check_eq("halt_ir",         32'(ir), 32'hF800);
    check_eq("halt_exec_en",    enables(), 32'h0);
    tick();
    check_eq("halt_idle",   32'(state), 32'd0);
    check_eq("halt_flag",   32'(halted), 32'd1);
    check_eq("halt_ret",    32'(retired), 32'd3);
    tick();
    tick();
    check_eq("halt_stay",   32'(state), 32'd0);
    check_eq("halt_no_req", 32'(imem_req), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("halt_step_run_ign", 32'(state), 32'd0);
    check_eq("halt_step_run_flag", 32'(halted), 32'd1);
    run = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    check_eq("halt_step_fetch", 32'(state), 32'd1);
    check_eq("halt_step_clr",   32'(halted), 32'd0);
    tick();
    tick();
    check_eq("halt_again", 32'(halted), 32'd1);

    // Reset during FETCH
    imem_ack = 1'b0;
    tick();
    run = 1'b1;
    tick();
    check_eq("rstf_req_before", 32'(imem_req), 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("rstf_state", 32'(state), 32'd0);
    check_eq("rstf_ir",    32'(ir), 32'h0);
    check_eq("rstf_req",   32'(imem_req), 32'd0);
    check_eq("rstf_halted", 32'(halted), 32'd0);

    // Reset during EXEC
    reset_n = 1'b1; imem_ack = 1'b1; imem_data = 16'h0900;
    dec_wr_en = 1'b1; dec_stat_wr_en = 1'b0; dec_cnt_wr_en = 1'b0;
    tick();
    tick();
    check_eq("rste_wr_before", 32'(rf_wr_en), 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("rste_en",    enables(), 32'h0);
    check_eq("rste_state", 32'(state), 32'd0);
    check_eq("rste_ret",   32'(retired), 32'd0);
    do_reset();

    // Fetch timeout: 15 ack-less FETCH cycles then FAULT
    run = 1'b1; imem_ack = 1'b0;
    tick();
    repeat (14) tick();
    check_eq("to_last_fetch", 32'(state), 32'd1);
    tick();
    check_eq("to_fault_state", 32'(state), 32'd3);
    check_eq("to_fault_flag",  32'(fault), 32'd1);
    check_eq("to_fault_req",   32'(imem_req), 32'd0);
    imem_ack = 1'b1; step = 1'b1; run = 1'b0;
    repeat (3) tick();
    step = 1'b0;
    check_eq("to_sticky_state", 32'(state), 32'd3);
    check_eq("to_sticky_flag",  32'(fault), 32'd1);
    check_eq("to_sticky_en",    enables(), 32'h0);
    check_eq("to_sticky_req",   32'(imem_req), 32'd0);
    do_reset();
    check_eq("to_rst_state", 32'(state), 32'd0);
    check_eq("to_rst_fault", 32'(fault), 32'd0);

    // Ack on the 15th FETCH cycle still completes the fetch
    run = 1'b1; imem_ack = 1'b0; imem_data = 16'h0900;
    tick();
    repeat (14) tick();
    imem_ack = 1'b1;
    tick();
    check_eq("to_late_ack_exec", 32'(state), 32'd2);
    imem_ack = 1'b0; run = 1'b0;
    tick();
    check_eq("to_late_ack_idle",  32'(state), 32'd0);
    check_eq("to_late_ack_fault", 32'(fault), 32'd0);

    // Retired counter wrap (4-bit instance wraps after 16 EXECs)
    do_reset();
    run = 1'b1; imem_ack = 1'b1; imem_data = 16'h0900;
    tick();
    repeat (15) begin
      tick();
      tick();
    end
    check_eq("wrap_ret16_pre", 32'(retired), 32'd15);
    check_eq("wrap_ret4_pre",  32'(w4_retired), 32'hF);
    tick();
    tick();
    check_eq("wrap_ret16_post", 32'(retired), 32'd16);
    check_eq("wrap_ret4_post",  32'(w4_retired), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
